// File: rtl/riscv_pkg.sv
// Shared RV32I load/store width encodings and the responder FSM state type.
package riscv_pkg;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory request/response handshake bundle.
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane write enables, store data replication, load extraction/extension and
// format (funct3 legality / alignment) error detection.
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data,
  output logic        fmt_err
);

  logic [31:0] shifted;
  logic        illegal;
  logic        misaligned;

  assign shifted = rdata_word >> {addr_lo, 3'b000};

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = wdata;
    load_data   = '0;
    illegal     = 1'b0;
    misaligned  = 1'b0;
    case (funct3)
      Funct3B: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        load_data   = {{24{shifted[7]}}, shifted[7:0]};
      end
      Funct3Bu: begin
        illegal   = we;
        load_data = {24'b0, shifted[7:0]};
      end
      Funct3H: begin
        misaligned  = addr_lo[0];
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        load_data   = {{16{shifted[15]}}, shifted[15:0]};
      end
      Funct3Hu: begin
        illegal    = we;
        misaligned = addr_lo[0];
        load_data  = {16'b0, shifted[15:0]};
      end
      Funct3W: begin
        misaligned = |addr_lo;
        byte_en    = 4'b1111;
        load_data  = rdata_word;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign fmt_err = illegal | misaligned;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data memory responder: accepts one load/store, waits WAIT_CYCLES,
// performs the access on the edge entering RESP and holds the response until consumed.
module data_mem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IdxW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic            access;
  logic            accept;
  logic            from_bus;
  logic            acc_we;
  logic [2:0]      acc_funct3;
  logic [31:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic [IdxW-1:0] word_idx;
  logic            in_range;
  logic [3:0]      byte_en;
  logic [31:0]     wdata_lanes;
  logic [31:0]     load_data;
  logic            fmt_err;
  logic            acc_err;
  logic            mem_write;

  assign accept = (state_q == StIdle) & bus.req_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            access  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so use the live bus.
  assign from_bus   = (state_q == StIdle);
  assign acc_we     = from_bus ? bus.req_we     : we_q;
  assign acc_funct3 = from_bus ? bus.req_funct3 : funct3_q;
  assign acc_addr   = from_bus ? bus.req_addr   : addr_q;
  assign acc_wdata  = from_bus ? bus.req_wdata  : wdata_q;

  assign word_idx = acc_addr[IdxW+1:2];
  assign in_range = {2'b00, acc_addr[31:2]} < DEPTH_WORDS;

  mem_lane_align u_lane_align (
    .we          (acc_we),
    .funct3      (acc_funct3),
    .addr_lo     (acc_addr[1:0]),
    .wdata       (acc_wdata),
    .rdata_word  (mem[word_idx]),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data),
    .fmt_err     (fmt_err)
  );

  assign acc_err   = fmt_err | ~in_range;
  assign mem_write = access & acc_we & ~acc_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
      if (access) begin
        rdata_q <= (acc_err | acc_we) ? '0 : load_data;
        err_q   <= acc_err;
      end else if ((state_q == StResp) && bus.rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_WORDS=1024, WAIT_CYCLES=2).
module tb_data_mem_responder;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; starts and ends one step after a rising edge with the DUT idle.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata,
                     output logic err, output int lat);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    if (bus.rsp_valid) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic op(input string tag, input logic we, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(we, f3, addr, wdata, rd, er, lat);
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " rdata"}, rd, exp_rdata);
    check({tag, " err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] held;
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op("sw 10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    op("lw 10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    op("lb 13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    op("lbu 13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    op("lh 10", 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    op("lhu 12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    op("lbu 10", 1'b0, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0);

    op("sb 11", 1'b1, 3'b000, 32'h11, 32'hAAAAAA55, 32'h0, 1'b0);
    op("lw after sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);

    op("lw 12 misal", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    op("sh 11 misal", 1'b1, 3'b001, 32'h11, 32'h1234, 32'h0, 1'b1);
    op("st f3 100", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1);
    op("ld f3 011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    op("lw after errs", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
    op("lw oor", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
    op("sw oor", 1'b1, 3'b010, 32'h1000, 32'h1, 32'h0, 1'b1);

    op("sh 12", 1'b1, 3'b001, 32'h12, 32'h7777A5A5, 32'h0, 1'b0);
    op("lw after sh", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A555EF, 1'b0);
    op("lh 12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFA5A5, 1'b0);

    // Stall in RESP for 5 cycles while a store is presented and must be ignored.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stall rsp_valid enter", {31'b0, bus.rsp_valid}, 32'd1);
    held           = bus.rsp_rdata;
    check("stall rdata", held, 32'hA5A555EF);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_wdata  = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("stall rdata hold", bus.rsp_rdata, 32'hA5A555EF);
      check("stall req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("post hs req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("post hs rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    op("lw after stall", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A555EF, 1'b0);

    // Reset during WAIT of a store abandons it.
    op("sw 20 zero", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midwait req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("midwait rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("midwait rsp_rdata", bus.rsp_rdata, 32'd0);
    check("midwait rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op("lw 20 after rst", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
